// File: rtl/wishbone_arbiter_2to1.sv
// Two-master to one-slave Wishbone arbiter.
// Grants go round-robin on ties, a grant is never pre-empted, and a granted
// strobe that waits too long for a slave ack is cut off with an err pulse.
module wishbone_arbiter_2to1 #(
  parameter int TO_CYCLES = 64,
  parameter int CNT_W     = 10
) (
  input  logic        clk_i,
  input  logic        rst_n,
  // master 0
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_reg, state_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [1:0] granted;
  logic [1:0] m_stb;
  logic [1:0] m_cyc;
  logic [1:0] m_ack;
  logic [1:0] m_err;
  logic       act_stb;
  logic       timeout;

  assign m_stb   = {m1_stb_i, m0_stb_i};
  assign m_cyc   = {m1_cyc_i, m0_cyc_i};
  assign granted = {state_reg == GNT1, state_reg == GNT0};

  // A strobe only counts as a live request when its own cyc is also high.
  assign act_stb = |(granted & m_stb & m_cyc);
  // Ack beats the timeout when both land on the same cycle.
  assign timeout = act_stb && !s_ack_i && (cnt_reg == TO_LAST);

  // Per-master ack/err routing: only the granted master ever sees either.
  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    assign m_ack[gi] = s_ack_i & granted[gi];
    assign m_err[gi] = timeout & granted[gi];
  end

  assign m0_ack_o  = m_ack[0];
  assign m1_ack_o  = m_ack[1];
  assign m0_err_o  = m_err[0];
  assign m1_err_o  = m_err[1];
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  // Next grant: hold while the owner keeps cyc, hand over without an idle gap.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last_reg ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) state_next = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i) state_next = m0_cyc_i ? GNT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Round-robin pointer remembers whichever master was granted most recently.
  always_comb begin
    last_next = last_reg;
    if (state_next == GNT0) last_next = 1'b0;
    if (state_next == GNT1) last_next = 1'b1;
  end

  // Wait counter: counts unacked live strobe cycles, saturating, cleared by any break.
  always_comb begin
    cnt_next = cnt_reg;
    if ((state_next != state_reg) || !act_stb || s_ack_i || timeout) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Slave-side mux; stb/cyc are suppressed on the timeout cycle, everything is 0 when idle.
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    case (state_reg)
      GNT0: begin
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i & ~timeout;
        s_cyc_o  = m0_cyc_i & ~timeout;
      end
      GNT1: begin
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i & ~timeout;
        s_cyc_o  = m1_cyc_i & ~timeout;
      end
      default: ;
    endcase
  end

  // State registers; reset drops the bus immediately and favours m0 on the next tie.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter_2to1.sv
// Scoreboard bench for the 2:1 Wishbone arbiter: a transaction-level model
// predicts every cycle's outputs, a monitor pops and compares them.
module tb_wishbone_arbiter_2to1;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdat [2];
  logic [3:0]  m_sel  [2];
  logic [1:0]  m_we, m_stb, m_cyc;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] s_addr, s_wdat, s_rdat;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic [3:0]  s_sel;

  wishbone_arbiter_2to1 #(.TO_CYCLES(TO), .CNT_W(10)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_wdat[0]), .m0_data_o(m0_rdat),
    .m0_we_i(m_we[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]), .m0_sel_i(m_sel[0]),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_wdat[1]), .m1_data_o(m1_rdat),
    .m1_we_i(m_we[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]), .m1_sel_i(m_sel[1]),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_addr_o(s_addr), .s_data_o(s_wdat), .s_data_i(s_rdat),
    .s_we_o(s_we), .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_sel_o(s_sel), .s_ack_i(s_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc_no;
    logic [70:0] bus;    // {addr, data, we, sel, stb, cyc}
    logic [1:0]  ack;    // {m1, m0}
    logic [1:0]  err;
    logic [63:0] rdat;   // {m1, m0}
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cyc_no = 0;

  // Reference model: who owns the bus (-1 none), who wins the next tie,
  // and how many unanswered strobe cycles the owner has accumulated.
  int owner     = -1;
  int tie_pick  = 0;
  int waited    = 0;

  task automatic model_reset();
    owner    = -1;
    tie_pick = 0;
    waited   = 0;
  endtask

  task automatic drive(input logic rst, input logic c0, input logic s0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic c1, input logic s1,
                       input logic [31:0] a1, input logic [31:0] d1, input logic ack);
    exp_t e;
    logic live, to;
    int   nxt;
    @(negedge clk);
    cyc_no++;
    rst_n     = rst;
    m_cyc     = {c1, c0};
    m_stb     = {s1, s0};
    m_addr[0] = a0;
    m_addr[1] = a1;
    m_wdat[0] = d0;
    m_wdat[1] = d1;
    m_we      = 2'($urandom_range(0, 3));
    m_sel[0]  = 4'($urandom_range(0, 15));
    m_sel[1]  = 4'($urandom_range(0, 15));
    s_rdat    = $urandom;
    s_ack     = ack;
    if (!rst) model_reset();

    live = (owner >= 0) && m_stb[owner] && m_cyc[owner];
    to   = live && !ack && (waited == TO - 1);
    e.cyc_no = cyc_no;
    e.bus    = '0;
    e.ack    = '0;
    e.err    = '0;
    e.rdat   = {s_rdat, s_rdat};
    if (owner >= 0) begin
      e.bus = {m_addr[owner], m_wdat[owner], m_we[owner], m_sel[owner],
               m_stb[owner] && !to, m_cyc[owner] && !to};
      e.ack[owner] = ack;
      e.err[owner] = to;
    end
    exp_q.push_back(e);

    if (rst) begin
      if (owner < 0) begin
        if (c0 && c1) nxt = tie_pick;
        else if (c0)  nxt = 0;
        else if (c1)  nxt = 1;
        else          nxt = -1;
      end else if (m_cyc[owner]) begin
        nxt = owner;
      end else begin
        nxt = m_cyc[1 - owner] ? 1 - owner : -1;
      end
      if (nxt != owner || !live || ack || to) waited = 0;
      else                                     waited = waited + 1;
      if (nxt >= 0) tie_pick = 1 - nxt;
      owner = nxt;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: samples between edges and checks each predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({s_addr, s_wdat, s_we, s_sel, s_stb, s_cyc} !== e.bus) begin
          fails++;
          $display("FAIL s_bus cycle %0d: got %h want %h", e.cyc_no,
                   {s_addr, s_wdat, s_we, s_sel, s_stb, s_cyc}, e.bus);
        end
        tests++;
        if ({m1_ack, m0_ack} !== e.ack) begin
          fails++;
          $display("FAIL ack cycle %0d: got %b want %b", e.cyc_no, {m1_ack, m0_ack}, e.ack);
        end
        tests++;
        if ({m1_err, m0_err} !== e.err) begin
          fails++;
          $display("FAIL err cycle %0d: got %b want %b", e.cyc_no, {m1_err, m0_err}, e.err);
        end
        tests++;
        if ({m1_rdat, m0_rdat} !== e.rdat) begin
          fails++;
          $display("FAIL rdata cycle %0d: got %h want %h", e.cyc_no, {m1_rdat, m0_rdat}, e.rdat);
        end
      end
    end
  end

  initial begin
    logic rc0, rc1, rs0, rs1, rst, rack;
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_rdat = '0;
    m_addr[0] = '0; m_addr[1] = '0; m_wdat[0] = '0; m_wdat[1] = '0;
    m_sel[0] = '0; m_sel[1] = '0;

    // Reset with busy inputs: every control output must stay low.
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 32'h11, 32'h22, 1, 1, 32'h33, 32'h44, 1);
    idle(2);

    // Single master write, slave acks two cycles after the grant appears.
    drive(1, 1, 1, 32'h4, 32'hA5, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 32'h4, 32'hA5, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 32'h4, 32'hA5, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 32'h4, 32'hA5, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // ack in IDLE is dropped
    idle(1);

    // Fresh reset, then repeated ties alternate m0, m1, m0 with no idle gap.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    drive(1, 1, 1, 32'hA0, 1, 1, 1, 32'hB0, 2, 0);
    drive(1, 1, 1, 32'hA0, 1, 1, 1, 32'hB0, 2, 1);
    drive(1, 0, 0, 32'hA0, 1, 1, 1, 32'hB0, 2, 0);
    drive(1, 0, 0, 32'hA0, 1, 1, 1, 32'hB0, 2, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    drive(1, 1, 1, 32'hA1, 3, 1, 1, 32'hB1, 4, 0);
    drive(1, 1, 1, 32'hA1, 3, 1, 1, 32'hB1, 4, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 32'hA2, 5, 1, 1, 32'hB2, 6, 0);
    drive(1, 1, 1, 32'hA2, 5, 1, 1, 32'hB2, 6, 0);
    idle(2);

    // No pre-emption: m0 holds cyc for 10 cycles while m1 keeps requesting.
    for (int i = 0; i < 10; i++) drive(1, 1, i[0], 32'hC0 + i, i, i > 1, 1, 32'hD0, 7, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 32'hD0, 7, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 32'hD0, 7, 1);
    idle(2);

    // Timeout: slave never acks; err on the 8th strobe cycle, grant kept.
    for (int i = 0; i < 12; i++) drive(1, 1, 1, 32'hE0, 8, 0, 0, 0, 0, 0);
    idle(1);
    // Same again with an ack landing exactly on the 8th strobe cycle.
    for (int i = 0; i < 10; i++) drive(1, 1, 1, 32'hE4, 9, 0, 0, 0, 0, i == 8);
    idle(1);

    // Reset pulsed mid-GNT1 between edges, then a tie goes to m0.
    drive(1, 0, 0, 0, 0, 1, 1, 32'hF0, 10, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 32'hF0, 10, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 32'hF0, 10, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 32'hA3, 11, 1, 1, 32'hB3, 12, 0);
    drive(1, 1, 1, 32'hA3, 11, 1, 1, 32'hB3, 12, 1);
    idle(2);

    // Randomised traffic with bursty requests, rare acks and rare resets.
    rc0 = 0; rc1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rc0 = ~rc0;
      if ($urandom_range(0, 5) == 0) rc1 = ~rc1;
      rs0  = rc0 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
      rs1  = rc1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
      rack = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 399) != 0);
      drive(rst, rc0, rs0, $urandom, $urandom, rc1, rs1, $urandom, $urandom, rack);
    end

    @(negedge clk);
    #4;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter_2to1.md
WISHBONE_ARBITER_2TO1 -- requirements
Module: wishbone_arbiter_2to1

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 64: the number of granted stb cycles without a slave ack before a timeout error is raised (range 2..1023).
REQ-002 SHALL have parameter CNT_W, default 10: the width of the timeout counter.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 m0_addr_i / m1_addr_i  in  32  master address.
REQ-006 m0_data_i / m1_data_i  in  32  master write data.
REQ-007 m0_data_o / m1_data_o  out  32  read data; both are driven from s_data_i.
REQ-008 m0_we_i / m1_we_i  in  1  write enable.
REQ-009 m0_stb_i / m1_stb_i  in  1  strobe.
REQ-010 m0_cyc_i / m1_cyc_i  in  1  bus cycle; acts as the bus request.
REQ-011 m0_sel_i / m1_sel_i  in  4  byte select.
REQ-012 m0_ack_o / m1_ack_o  out  1  acknowledge, routed to the granted master only.
REQ-013 m0_err_o / m1_err_o  out  1  one-cycle timeout error pulse.
REQ-014 s_addr_o, s_data_o  out  32 each  address and write data to the shared slave (e.g. the UART adapter).
REQ-015 s_data_i  in  32  slave read data.
REQ-016 s_we_o, s_stb_o, s_cyc_o  out  1 each  slave control.
REQ-017 s_sel_o  out  4  slave byte select.
REQ-018 s_ack_i  in  1  slave acknowledge.

Function
REQ-019 SHALL implement FSM states IDLE, GNT0, GNT1 and a registered round-robin pointer last (0 = m0 granted last, 1 = m1 granted last).
REQ-020 IDLE transitions:
- only m0_cyc_i high -> GNT0.
- only m1_cyc_i high -> GNT1.
- both high -> grant the master other than last.
- the grant is visible in the cycle after the request (1-cycle arbitration latency).
REQ-021 On entry to GNTx, last SHALL be set to x.
REQ-022 GNTx SHALL hold while mx_cyc_i=1; the grant is never pre-empted during a cycle.
REQ-023 When mx_cyc_i falls in GNTx, the next state SHALL be GNTy if the other master's cyc is high, else IDLE.
REQ-024 In GNTx, the s_* outputs SHALL combinationally mirror master x's addr, data, we, sel, stb and cyc.
REQ-025 In IDLE, all s_* outputs SHALL be 0.
REQ-026 mx_ack_o SHALL equal s_ack_i AND (state==GNTx); the non-granted master's ack and err SHALL be 0.
REQ-027 Timeout counter behaviour:
- increments each cycle in GNTx with mx_stb_i=1 and s_ack_i=0.
- clears on s_ack_i=1, on stb low, or on a state change.
- saturates; it never wraps.
REQ-028 When the counter equals TO_CYCLES-1 with no ack, then in that cycle:
- mx_err_o SHALL pulse for exactly one cycle.
- s_stb_o and s_cyc_o SHALL be forced to 0.
- the counter SHALL clear.
- the grant is retained while mx_cyc_i remains high.
REQ-029 If s_ack_i=1 in the same cycle the timeout would fire, ack SHALL win: ack is delivered and no err is raised.
REQ-030 A slave ack arriving in IDLE SHALL be dropped and SHALL NOT reach any master.
REQ-031 A master raising stb without cyc SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, last=1, counter=0.
REQ-033 During and after reset, all outputs except mx_data_o SHALL read 0: all s_* control outputs, all acks and all errs.
REQ-034 Reset asserted mid-transaction SHALL abort it with no ack or err.
REQ-035 After reset release, the first tied request SHALL be granted to m0.

Verification
REQ-036 Single master: m0 cyc/stb write 0x0000_00A5 to addr 0x4; slave acks 2 cycles later -> s_cyc_o rises 1 cycle after the request, s_data_o=0xA5, m0_ack_o pulses once, m1_ack_o stays 0.
REQ-037 Tie after reset: both cyc rise in the same cycle -> GNT0 first; on m0 release with m1 still requesting -> GNT1 the next cycle with no IDLE gap; repeated ties alternate m0, m1, m0.
REQ-038 No pre-emption: m1 requests while m0 holds cyc for 10 cycles -> s_addr_o tracks m0 throughout, then switches to m1 the cycle after m0 cyc falls.
REQ-039 Timeout: TO_CYCLES=8, slave never acks -> m0_err_o pulses on the 8th stb cycle and s_stb_o=0 in that cycle; with a late ack on that same cycle -> ack delivered and err=0.
REQ-040 Async reset: rst_n pulsed low mid-GNT1 between clock edges -> s_cyc_o=0 and m1_ack_o=0 before the next edge; the next tie is granted to m0.
